// File: rtl/mips32_prog_loader.sv
// -----------------------------------------------------------------------------
// mips32_prog_loader
//
// Loads a program image into the MIPS32 instruction/data memory from a byte
// stream and then releases the core. The loader shares the memory port with
// the core's fetch path and acts as its writer. It keeps the core halted
// during the load and pulses a restart once the image is complete.
//
// Stream format: a 16-bit word count N (MSB byte first), followed by N words
// of 4 bytes each (MSB byte first).
//
// Optional feature (macro LOADER_CHECKSUM_EN): a trailing checksum byte is
// required after the last data word. It must equal the XOR of all data
// bytes. On a mismatch the loader enters the error state and no restart is
// pulsed.
//
// Parameters:
//   ADDR_W      memory word-address width (depth = 2**ADDR_W words)
//   START_ADDR  first word address written (< 2**ADDR_W)
//
// Ports:
//   clk1         system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a load session (honoured in IDLE/DONE/ERR only)
//   byte_valid   stream byte present
//   byte_data    stream byte
//   byte_ready   loader accepts a byte this cycle (transfer = valid & ready)
//   mem_we       one-cycle memory write strobe
//   mem_addr     word address for the write
//   mem_wdata    word to write
//   cpu_halt     hold the core (drives HALTED)
//   cpu_restart  one-cycle pulse: core clears PC, TAKEN_BRANCH, HALTED
//   load_done    image loaded successfully (sticky until next start)
//   load_err     session aborted (sticky until next start)
// -----------------------------------------------------------------------------
module mips32_prog_loader #(
    parameter int ADDR_W     = 10,
    parameter int START_ADDR = 0
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_halt,
    output logic              cpu_restart,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_FIN,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHK
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    // One past the last legal word address; START_ADDR + N must not exceed it.
    localparam logic [31:0]       LIMIT   = 32'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    // Running checksum update over the data bytes.
    function automatic logic [7:0] xsum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [15:0]       cnt_r, cnt_nxt_s;
    logic [31:0]       word_r, word_nxt_s;
    logic [1:0]        bidx_r, bidx_nxt_s;
    logic              byte_ready_r, byte_ready_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic              cpu_halt_r, cpu_halt_nxt_s;
    logic              cpu_restart_r, cpu_restart_nxt_s;
    logic              load_done_r, load_done_nxt_s;
    logic              load_err_r, load_err_nxt_s;
    logic              xfer_s;
    logic [15:0]       n_s;
    logic [31:0]       end_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xsum_r, xsum_nxt_s;
`endif

    assign xfer_s = byte_valid & byte_ready_r;

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        cnt_nxt_s   = cnt_r;
        word_nxt_s  = word_r;
        bidx_nxt_s  = bidx_r;
        n_s         = {cnt_r[15:8], byte_data};
        end_s       = 32'(START_ADDR) + 32'(n_s);
`ifdef LOADER_CHECKSUM_EN
        xsum_nxt_s  = xsum_r;
`endif
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt_s = S_CNT_HI;
                    addr_nxt_s  = START_A;
                    bidx_nxt_s  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    xsum_nxt_s  = 8'h00;
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_CNT_HI: begin
                if (xfer_s) begin
                    cnt_nxt_s   = {byte_data, cnt_r[7:0]};
                    state_nxt_s = S_CNT_LO;
                end else begin
                    state_nxt_s = S_CNT_HI;
                end
            end
            S_CNT_LO: begin
                if (xfer_s) begin
                    cnt_nxt_s  = n_s;
                    bidx_nxt_s = 2'd0;
                    if (n_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt_s = S_CHK;
`else
                        state_nxt_s = S_FIN;
`endif
                    end else if (end_s > LIMIT) begin
                        state_nxt_s = S_ERR;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end else begin
                    state_nxt_s = S_CNT_LO;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    word_nxt_s = {word_r[23:0], byte_data};
                    bidx_nxt_s = bidx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xsum_nxt_s = xsum_step(xsum_r, byte_data);
`endif
                    if (bidx_r == 2'd3) begin
                        state_nxt_s = S_WRITE;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_WRITE: begin
                cnt_nxt_s = cnt_r - 16'd1;
                if (cnt_r == 16'd1) begin
                    // Address is held on the last word so it never wraps.
`ifdef LOADER_CHECKSUM_EN
                    state_nxt_s = S_CHK;
`else
                    state_nxt_s = S_FIN;
`endif
                end else begin
                    addr_nxt_s  = addr_r + ADDR_W'(1);
                    state_nxt_s = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer_s) begin
                    if (byte_data == xsum_r) begin
                        state_nxt_s = S_FIN;
                    end else begin
                        state_nxt_s = S_ERR;
                    end
                end else begin
                    state_nxt_s = S_CHK;
                end
            end
`endif
            S_FIN: begin
                state_nxt_s = S_DONE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is driven by a flop.
    always_comb begin
        byte_ready_nxt_s  = 1'b0;
        mem_we_nxt_s      = 1'b0;
        cpu_halt_nxt_s    = 1'b1;
        cpu_restart_nxt_s = 1'b0;
        load_done_nxt_s   = 1'b0;
        load_err_nxt_s    = 1'b0;
        case (state_nxt_s)
            S_CNT_HI, S_CNT_LO, S_DATA: byte_ready_nxt_s  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                      byte_ready_nxt_s  = 1'b1;
`endif
            S_WRITE:                    mem_we_nxt_s      = 1'b1;
            S_FIN:                      cpu_restart_nxt_s = 1'b1;
            S_DONE: begin
                load_done_nxt_s = 1'b1;
                cpu_halt_nxt_s  = 1'b0;
            end
            S_ERR:                      load_err_nxt_s    = 1'b1;
            default:                    byte_ready_nxt_s  = 1'b0;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            addr_r        <= START_A;
            cnt_r         <= 16'd0;
            word_r        <= 32'd0;
            bidx_r        <= 2'd0;
            byte_ready_r  <= 1'b0;
            mem_we_r      <= 1'b0;
            cpu_halt_r    <= 1'b1;
            cpu_restart_r <= 1'b0;
            load_done_r   <= 1'b0;
            load_err_r    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xsum_r        <= 8'h00;
`endif
        end else begin
            state_r       <= state_nxt_s;
            addr_r        <= addr_nxt_s;
            cnt_r         <= cnt_nxt_s;
            word_r        <= word_nxt_s;
            bidx_r        <= bidx_nxt_s;
            byte_ready_r  <= byte_ready_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            cpu_halt_r    <= cpu_halt_nxt_s;
            cpu_restart_r <= cpu_restart_nxt_s;
            load_done_r   <= load_done_nxt_s;
            load_err_r    <= load_err_nxt_s;
`ifdef LOADER_CHECKSUM_EN
            xsum_r        <= xsum_nxt_s;
`endif
        end
    end

    assign byte_ready  = byte_ready_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = addr_r;
    assign mem_wdata   = word_r;
    assign cpu_halt    = cpu_halt_r;
    assign cpu_restart = cpu_restart_r;
    assign load_done   = load_done_r;
    assign load_err    = load_err_r;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// -----------------------------------------------------------------------------
// Testbench for mips32_prog_loader. There are two instances: the default
// geometry (ADDR_W=10, START_ADDR=0) and a small one (ADDR_W=4, START_ADDR=14)
// that exercises the range check at the top of memory. A select bit steers
// the shared stimulus to one instance at a time. Expected writes are queued as
// each word is driven and are popped by a monitor when mem_we is seen.
// -----------------------------------------------------------------------------
module tb_mips32_prog_loader;

    logic        clk1;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        sel;

    logic        start0, start1, v0, v1;
    logic        r0, we0, h0, rs0, dn0, er0;
    logic        r1, we1, h1, rs1, dn1, er1;
    logic [9:0]  a0;
    logic [3:0]  a1;
    logic [31:0] d0, d1;

    assign start0 = start & ~sel;
    assign v0     = byte_valid & ~sel;
    assign start1 = start & sel;
    assign v1     = byte_valid & sel;

    mips32_prog_loader #(.ADDR_W(10), .START_ADDR(0)) dut0 (
        .clk1(clk1), .rst_n(rst_n), .start(start0), .byte_valid(v0),
        .byte_data(byte_data), .byte_ready(r0), .mem_we(we0), .mem_addr(a0),
        .mem_wdata(d0), .cpu_halt(h0), .cpu_restart(rs0), .load_done(dn0),
        .load_err(er0)
    );

    mips32_prog_loader #(.ADDR_W(4), .START_ADDR(14)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .start(start1), .byte_valid(v1),
        .byte_data(byte_data), .byte_ready(r1), .mem_we(we1), .mem_addr(a1),
        .mem_wdata(d1), .cpu_halt(h1), .cpu_restart(rs1), .load_done(dn1),
        .load_err(er1)
    );

    logic rdy_s, we_s, h_s, dn_s, er_s;
    assign rdy_s = sel ? r1  : r0;
    assign we_s  = sel ? we1 : we0;
    assign h_s   = sel ? h1  : h0;
    assign dn_s  = sel ? dn1 : dn0;
    assign er_s  = sel ? er1 : er0;

    int npass  = 0;
    int ntotal = 0;
    int wr0 = 0, wr1 = 0, rc0 = 0, rc1 = 0;
    logic [41:0] exp0[$];
    logic [41:0] exp1[$];
    logic [31:0] img_q[$];
    logic        last_we, last_rdy;

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Write/restart monitor: scoreboard pop on every mem_we.
    always @(negedge clk1) begin
        logic [41:0] e;
        if (we0 === 1'b1) begin
            wr0++;
            if (exp0.size() == 0) check("w0_unexpected", 32'(we0), 32'd0);
            else begin
                e = exp0.pop_front();
                check("w0_addr", 32'(a0), 32'(e[41:32]));
                check("w0_data", d0, e[31:0]);
            end
        end
        if (rs0 === 1'b1) begin
            rc0++;
            check("w0_restart_with_we", 32'(we0), 32'd0);
        end
        if (we1 === 1'b1) begin
            wr1++;
            if (exp1.size() == 0) check("w1_unexpected", 32'(we1), 32'd0);
            else begin
                e = exp1.pop_front();
                check("w1_addr", 32'({6'd0, a1}), 32'(e[41:32]));
                check("w1_data", d1, e[31:0]);
            end
        end
        if (rs1 === 1'b1) begin
            rc1++;
            check("w1_restart_with_we", 32'(we1), 32'd0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        byte_data  = b;
        byte_valid = 1'b1;
        t = 0;
        while (rdy_s !== 1'b1 && t < 50) begin
            @(negedge clk1);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'(rdy_s), 32'd1);
        @(posedge clk1);
        @(negedge clk1);
        last_we    = we_s;
        last_rdy   = rdy_s;
        byte_valid = 1'b0;
        if (gap) @(negedge clk1);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(dn_s === 1'b1 || er_s === 1'b1) && t < 40) begin
            @(negedge clk1);
            t++;
        end
        check("end_reached", 32'(dn_s | er_s), 32'd1);
    endtask

    task automatic push_exp(input logic [9:0] addr, input logic [31:0] w);
        if (sel) exp1.push_back({addr, w});
        else     exp0.push_back({addr, w});
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, inout logic [7:0] cs);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8], gap);
            cs = cs ^ w[8*k +: 8];
            if (k == 0) begin
                check("we_after_4th", 32'(last_we), 32'd1);
                check("ready_low_in_write", 32'(last_rdy), 32'd0);
            end else begin
                check("no_early_we", 32'(last_we), 32'd0);
            end
        end
    endtask

    task automatic run_load(input logic [9:0] base, input bit gap, input logic [7:0] flip);
        logic [15:0] n;
        logic [7:0]  cs;
        n  = 16'(img_q.size());
        cs = 8'h00;
        pulse_start();
        check("start_ready", 32'(rdy_s), 32'd1);
        check("start_halt", 32'(h_s), 32'd1);
        check("start_done_clr", 32'(dn_s), 32'd0);
        check("start_err_clr", 32'(er_s), 32'd0);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        for (int i = 0; i < int'(n); i++) begin
            push_exp(base + 10'(i), img_q[i]);
            send_word(img_q[i], gap, cs);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs ^ flip, gap);
`else
        if (flip != 8'h00) cs = cs ^ flip;
`endif
        wait_end();
    endtask

    task automatic load_main_image();
        img_q = {32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    endtask

    task automatic check_done(input string tag, input int nwr);
        check({tag, "_done"}, 32'(dn_s), 32'd1);
        check({tag, "_halt"}, 32'(h_s), 32'd0);
        check({tag, "_err"}, 32'(er_s), 32'd0);
        check({tag, "_writes"}, 32'(sel ? wr1 : wr0), 32'(nwr));
        check({tag, "_restarts"}, 32'(sel ? rc1 : rc0), 32'd1);
        check({tag, "_queue"}, 32'(sel ? exp1.size() : exp0.size()), 32'd0);
        check({tag, "_ready_idle"}, 32'(rdy_s), 32'd0);
    endtask

    initial begin
        logic [7:0] cs;
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; sel = 1'b0;
        repeat (3) @(negedge clk1);
        check("rst_halt", 32'(h0), 32'd1);
        check("rst_ready", 32'(r0), 32'd0);
        check("rst_we", 32'(we0), 32'd0);
        check("rst_done", 32'(dn0), 32'd0);
        check("rst_err", 32'(er0), 32'd0);
        check("rst_restart", 32'(rs0), 32'd0);
        check("rst_addr0", 32'(a0), 32'd0);
        check("rst_wdata", d0, 32'd0);
        check("rst_addr1", 32'({6'd0, a1}), 32'd14);
        rst_n = 1'b1;
        @(negedge clk1);
        check("idle_ready", 32'(r0), 32'd0);

        // Main image, continuous stream.
        load_main_image();
        wr0 = 0; rc0 = 0;
        run_load(10'd0, 1'b0, 8'h00);
        check_done("img", 9);

        // Same image, byte_valid toggling every cycle.
        wr0 = 0; rc0 = 0;
        run_load(10'd0, 1'b1, 8'h00);
        check_done("img_gap", 9);

        // Small memory: N=3 from address 14 overflows.
        sel = 1'b1;
        @(negedge clk1);
        wr1 = 0; rc1 = 0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        repeat (3) @(negedge clk1);
        check("ovf_err", 32'(er1), 32'd1);
        check("ovf_halt", 32'(h1), 32'd1);
        check("ovf_ready", 32'(r1), 32'd0);
        check("ovf_done", 32'(dn1), 32'd0);
        check("ovf_writes", 32'(wr1), 32'd0);
        check("ovf_restarts", 32'(rc1), 32'd0);
        img_q = {32'hdeadbeef, 32'h01234567};
        run_load(10'd14, 1'b0, 8'h00);
        check_done("top_fit", 2);

        // Reset part way through word 3.
        sel = 1'b0;
        @(negedge clk1);
        load_main_image();
        wr0 = 0; rc0 = 0; cs = 8'h00;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h09, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_exp(10'(i), img_q[i]);
            send_word(img_q[i], 1'b0, cs);
        end
        send_byte(8'h0c, 1'b0);
        send_byte(8'he7, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_halt", 32'(h0), 32'd1);
        check("mid_rst_ready", 32'(r0), 32'd0);
        check("mid_rst_we", 32'(we0), 32'd0);
        check("mid_rst_addr", 32'(a0), 32'd0);
        check("mid_rst_done", 32'(dn0), 32'd0);
        repeat (3) @(negedge clk1);
        check("mid_rst_writes", 32'(wr0), 32'd3);
        check("mid_rst_queue", 32'(exp0.size()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk1);
        wr0 = 0; rc0 = 0;
        run_load(10'd0, 1'b0, 8'h00);
        check_done("after_rst", 9);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good (0x08) then bad (0x09).
        img_q = {32'h12345678};
        wr0 = 0; rc0 = 0;
        run_load(10'd0, 1'b0, 8'h00);
        check_done("chk_good", 1);
        wr0 = 0; rc0 = 0;
        run_load(10'd0, 1'b0, 8'h01);
        repeat (2) @(negedge clk1);
        check("chk_bad_err", 32'(er0), 32'd1);
        check("chk_bad_halt", 32'(h0), 32'd1);
        check("chk_bad_writes", 32'(wr0), 32'd1);
        check("chk_bad_restarts", 32'(rc0), 32'd0);
        check("chk_bad_done", 32'(dn0), 32'd0);
`endif

        repeat (2) @(negedge clk1);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
